ip_scc_wavetable: RTL

Parametrised SCC-class wavetable sound generator, successor to `ip_scc`. It provides CHANNELS independent channels, each with a 2^WAVE_DEPTH_LOG2-entry signed 8-bit waveform, a 12-bit period counter, a 4-bit volume and a key-on bit. A sequential mixer sums all channels into one signed PCM word once per `enable` strobe. It sits behind the cartridge bus decoder, which drives the register port, and feeds the audio output stage.

---
 rtl/ip_scc_wavetable.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ip_scc_wavetable.sv
// SCC-class wavetable generator: per-channel flop waveform RAM, period counter
// and pointer, plus a sequential one-channel-per-clk mixer triggered by enable.

module ip_scc_wavetable_voice #(
  parameter int WAVE_DEPTH_LOG2 = 5
) (
  input  logic                       n_reset,
  input  logic                       clk,
  input  logic                       enable,
  input  logic [11:0]                freq,
  input  logic                       freq_wr,
  input  logic [11:0]                freq_new,
  input  logic                       wave_wr,
  input  logic [WAVE_DEPTH_LOG2-1:0] wave_idx,
  input  logic [7:0]                 wave_data,
  output logic [7:0]                 sample,
  output logic [7:0]                 bus_sample
);
  localparam int DEPTH = 1 << WAVE_DEPTH_LOG2;

  logic [DEPTH-1:0][7:0]       wave;
  logic [11:0]                 cnt;
  logic [WAVE_DEPTH_LOG2-1:0]  ptr;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)     wave <= '0;
    else if (wave_wr) wave[wave_idx] <= wave_data;
  end

  // A freq write reloads the counter and beats a coincident tick; the
  // pointer only moves on a tick that is not overridden.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt <= '0;
      ptr <= '0;
    end else if (freq_wr) begin
      cnt <= freq_new;
    end else if (enable && freq >= 12'd9) begin
      if (cnt == 12'd0) begin
        cnt <= freq;
        ptr <= ptr + WAVE_DEPTH_LOG2'(1);
      end else begin
        cnt <= cnt - 12'd1;
      end
    end
  end

  assign sample     = wave[ptr];
  assign bus_sample = wave[wave_idx];
endmodule

module ip_scc_wavetable #(
  parameter int CHANNELS        = 5,
  parameter int WAVE_DEPTH_LOG2 = 5,
  parameter int OUT_WIDTH       = 11
) (
  input  logic                       n_reset,
  input  logic                       clk,
  input  logic                       enable,
  input  logic                       reg_space,
  input  logic [2+WAVE_DEPTH_LOG2:0] reg_address,
  input  logic                       reg_write,
  input  logic [7:0]                 reg_write_data,
  input  logic                       reg_read,
  output logic                       reg_read_ready,
  output logic [7:0]                 reg_read_data,
  output logic [OUT_WIDTH-1:0]       sound_out
);
  localparam int AW = 3 + WAVE_DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

  logic [CHANNELS-1:0][11:0] freq;
  logic [CHANNELS-1:0][11:0] freq_new;
  logic [CHANNELS-1:0][3:0]  volume;
  logic [CHANNELS-1:0]       key_on;
  logic [CHANNELS-1:0][7:0]  cur_sample;
  logic [CHANNELS-1:0][7:0]  bus_sample;
  logic [CHANNELS-1:0]       freq_lo_wr, freq_hi_wr, vol_wr, wave_wr;
  logic                      key_wr;

  logic [2:0]                 ram_ch;
  logic [WAVE_DEPTH_LOG2-1:0] ram_idx;
  logic [7:0]                 rd_val;

  state_t                       state, state_d;
  logic [2:0]                   ch, ch_d;
  logic signed [OUT_WIDTH-1:0]  acc, acc_d;
  logic [OUT_WIDTH-1:0]         sound_d;
  logic [7:0]                   sel_sample;
  logic [3:0]                   sel_vol;
  logic                         sel_key;
  logic signed [11:0]           prod;
  logic signed [OUT_WIDTH-1:0]  term_ext;

  assign ram_ch  = reg_address[AW-1 -: 3];
  assign ram_idx = reg_address[WAVE_DEPTH_LOG2-1:0];

  // Write decode; full control address is matched so stray indices are ignored
  always_comb begin
    freq_lo_wr = '0;
    freq_hi_wr = '0;
    vol_wr     = '0;
    wave_wr    = '0;
    freq_new   = freq;
    for (int c = 0; c < CHANNELS; c++) begin
      wave_wr[c]    = reg_write && !reg_space && (ram_ch == 3'(c));
      freq_lo_wr[c] = reg_write && reg_space && (reg_address == AW'(2*c));
      freq_hi_wr[c] = reg_write && reg_space && (reg_address == AW'(2*c+1));
      vol_wr[c]     = reg_write && reg_space && (reg_address == AW'(2*CHANNELS+c));
      if (freq_lo_wr[c]) freq_new[c] = {freq[c][11:8], reg_write_data};
      if (freq_hi_wr[c]) freq_new[c] = {reg_write_data[3:0], freq[c][7:0]};
    end
    key_wr = reg_write && reg_space && (reg_address == AW'(3*CHANNELS));
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      freq   <= '0;
      volume <= '0;
      key_on <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (freq_lo_wr[c] || freq_hi_wr[c]) freq[c] <= freq_new[c];
        if (vol_wr[c]) volume[c] <= reg_write_data[3:0];
      end
      if (key_wr) key_on <= reg_write_data[CHANNELS-1:0];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
    ip_scc_wavetable_voice #(
      .WAVE_DEPTH_LOG2(WAVE_DEPTH_LOG2)
    ) u_voice (
      .n_reset    (n_reset),
      .clk        (clk),
      .enable     (enable),
      .freq       (freq[g]),
      .freq_wr    (freq_lo_wr[g] || freq_hi_wr[g]),
      .freq_new   (freq_new[g]),
      .wave_wr    (wave_wr[g]),
      .wave_idx   (ram_idx),
      .wave_data  (reg_write_data),
      .sample     (cur_sample[g]),
      .bus_sample (bus_sample[g])
    );
  end

  // Read mux sees pre-write state, so a same-clk write returns the old value
  always_comb begin
    rd_val = 8'hFF;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!reg_space) begin
        if (ram_ch == 3'(c)) rd_val = bus_sample[c];
      end else begin
        if (reg_address == AW'(2*c))            rd_val = freq[c][7:0];
        if (reg_address == AW'(2*c+1))          rd_val = {4'h0, freq[c][11:8]};
        if (reg_address == AW'(2*CHANNELS+c))   rd_val = {4'h0, volume[c]};
      end
    end
    if (reg_space && reg_address == AW'(3*CHANNELS)) rd_val = 8'(key_on);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      reg_read_ready <= 1'b0;
      reg_read_data  <= 8'h00;
    end else begin
      reg_read_ready <= reg_read;
      if (reg_read) reg_read_data <= rd_val;
    end
  end

  always_comb begin
    sel_sample = 8'h00;
    sel_vol    = 4'h0;
    sel_key    = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch == 3'(c)) begin
        sel_sample = cur_sample[c];
        sel_vol    = volume[c];
        sel_key    = key_on[c];
      end
    end
    prod     = $signed(sel_sample) * $signed({1'b0, sel_vol});
    term_ext = sel_key ? OUT_WIDTH'(prod >>> 4) : '0;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= S_IDLE;
      ch        <= '0;
      acc       <= '0;
      sound_out <= '0;
    end else begin
      state     <= state_d;
      ch        <= ch_d;
      acc       <= acc_d;
      sound_out <= sound_d;
    end
  end

  always_comb begin
    state_d = state;
    ch_d    = ch;
    acc_d   = acc;
    sound_d = sound_out;
    unique case (state)
      S_IDLE: if (enable) begin
        acc_d   = '0;
        ch_d    = '0;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        acc_d = acc + term_ext;
        if (ch == 3'(CHANNELS-1)) state_d = S_OUT;
        else                      ch_d    = ch + 3'd1;
      end
      S_OUT: begin
        sound_d = acc;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
